// File: rtl/transpose_pkg.sv
// Shared bank-state type and counter-width helpers for transpose_buf.
// Optional feature macro used by the design: TRANSPOSE_BUF_FLUSH_EN.
package transpose_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } bank_state_e;

   function automatic int row_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int col_cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/transpose_bank.sv
// One N x W matrix bank: row-write storage, EMPTY/FILL/FULL state and row count.
// With TRANSPOSE_BUF_FLUSH_EN a row-valid mask zeroes rows a flushed bank never received.
module transpose_bank
   import transpose_pkg::*;
#(
   parameter int N  = 5,
   parameter int W  = 5,
   parameter int RW = row_cnt_w(N),
   parameter int CW = col_cnt_w(W),
   parameter int NW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [RW-1:0] wr_row,
   input  logic [W-1:0]  wr_data,
   input  logic          wr_close,
   input  logic [NW-1:0] wr_rows,
   input  logic          rd_done,
   input  logic [CW-1:0] rd_col,
   output logic [N-1:0]  rd_data,
   output bank_state_e   state,
   output logic [NW-1:0] rows
);

   logic [W-1:0]  mem [N];
   bank_state_e   state_reg, state_next;
   logic [NW-1:0] rows_reg;
   logic [N-1:0]  row_ok;

   // Storage carries no reset: stale data is harmless once the state says EMPTY.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         rows_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (wr_close) rows_reg <= wr_rows;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         EMPTY:   if (wr_close) state_next = FULL;
                  else if (wr_en) state_next = FILL;
         FILL:    if (wr_close) state_next = FULL;
         FULL:    if (rd_done) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

`ifdef TRANSPOSE_BUF_FLUSH_EN
   logic [N-1:0] mask_reg;

   // The first row into an EMPTY bank restarts the mask from scratch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mask_reg <= '0;
      else if (wr_en)
         mask_reg <= ((state_reg == EMPTY) ? '0 : mask_reg) | (N'(1) << wr_row);
   end

   assign row_ok = mask_reg;
`else
   assign row_ok = '1;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_col
         assign rd_data[gi] = mem[gi][rd_col] & row_ok[gi];
      end
   endgenerate

   assign state = state_reg;
   assign rows  = rows_reg;

endmodule

// File: rtl/transpose_buf.sv
// Ping-pong bit-matrix transpose: N rows of W bits in, W columns of N bits out.
// Define TRANSPOSE_BUF_FLUSH_EN to add the flush port for closing partial matrices.
module transpose_buf
   import transpose_pkg::*;
#(
   parameter int N = 5,
   parameter int W = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [W-1:0]             in_data,
`ifdef TRANSPOSE_BUF_FLUSH_EN
   input  logic                     flush,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_data,
   output logic                     out_last,
   output logic [$clog2(N+1)-1:0]   out_rows
);

   localparam int RW = row_cnt_w(N);
   localparam int CW = col_cnt_w(W);
   localparam int NW = $clog2(N + 1);

   logic          wsel_reg, rsel_reg;
   logic [RW-1:0] wrow_reg;
   logic [CW-1:0] rcol_reg;
   logic [1:0]    wsel_oh, rsel_oh;
   bank_state_e   bstate [2];
   logic [N-1:0]  bcol   [2];
   logic [NW-1:0] brows  [2];
   logic          accept, last_row, flush_hit, close, fire, last_col;
   logic [NW-1:0] close_rows;

   assign wsel_oh  = {wsel_reg, ~wsel_reg};
   assign rsel_oh  = {rsel_reg, ~rsel_reg};

   assign in_ready = (bstate[wsel_reg] != FULL);
   assign accept   = in_valid && in_ready;
   assign last_row = (wrow_reg == RW'(N - 1));

`ifdef TRANSPOSE_BUF_FLUSH_EN
   assign flush_hit = flush && (bstate[wsel_reg] == FILL);
`else
   assign flush_hit = 1'b0;
`endif

   // A flush that coincides with the final row is just a normal completion.
   assign close      = (accept && last_row) || flush_hit;
   assign close_rows = (accept && last_row) ? NW'(N) : NW'(wrow_reg) + NW'(accept);

   assign out_valid = (bstate[rsel_reg] == FULL);
   assign fire      = out_valid && out_ready;
   assign last_col  = (rcol_reg == CW'(W - 1));
   assign out_data  = bcol[rsel_reg];
   assign out_last  = out_valid && last_col;
   assign out_rows  = out_valid ? brows[rsel_reg] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsel_reg <= 1'b0;
         rsel_reg <= 1'b0;
         wrow_reg <= '0;
         rcol_reg <= '0;
      end else begin
         if (close) begin
            wrow_reg <= '0;
            wsel_reg <= ~wsel_reg;
         end else if (accept) begin
            wrow_reg <= wrow_reg + RW'(1);
         end
         if (fire) begin
            if (last_col) begin
               rcol_reg <= '0;
               rsel_reg <= ~rsel_reg;
            end else begin
               rcol_reg <= rcol_reg + CW'(1);
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         transpose_bank #(.N(N), .W(W)) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (accept && wsel_oh[gi]),
            .wr_row   (wrow_reg),
            .wr_data  (in_data),
            .wr_close (close && wsel_oh[gi]),
            .wr_rows  (close_rows),
            .rd_done  (fire && last_col && rsel_oh[gi]),
            .rd_col   (rcol_reg),
            .rd_data  (bcol[gi]),
            .state    (bstate[gi]),
            .rows     (brows[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_transpose_buf.sv
// Self-checking bench for transpose_buf: table vectors, backpressure, streaming, reset, flush.
// Flush scenarios run only when TRANSPOSE_BUF_FLUSH_EN is defined.
`timescale 1ns/1ps
module tb_transpose_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
   logic [4:0] a_in_data, a_out_data;
   logic [2:0] a_out_rows;
`ifdef TRANSPOSE_BUF_FLUSH_EN
   logic       a_flush, b_flush;
`endif
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [7:0] b_in_data;
   logic [3:0] b_out_data;
   logic [2:0] b_out_rows;

   int pass_cnt = 0;
   int total_cnt = 0;

   transpose_buf #(.N(5), .W(5)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
`ifdef TRANSPOSE_BUF_FLUSH_EN
      .flush(a_flush),
`endif
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .out_rows(a_out_rows)
   );

   transpose_buf #(.N(4), .W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
`ifdef TRANSPOSE_BUF_FLUSH_EN
      .flush(b_flush),
`endif
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .out_rows(b_out_rows)
   );

   typedef struct packed {
      logic [4:0][4:0] r;
      logic [4:0][4:0] c;
   } vec_t;

   vec_t tbl [8];

   // Reference transpose: column j bit i is row i bit j.
   function automatic logic [4:0][4:0] xpose5(input logic [4:0][4:0] r);
      logic [4:0][4:0] c;
      for (int j = 0; j < 5; j++)
         for (int i = 0; i < 5; i++)
            c[j][i] = r[i][j];
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      total_cnt++;
      $display("FAIL %s: handshake bound expired, got none, expected handshake", name);
   endtask

   // All tasks start and end at posedge+1, so no edge passes unobserved.
   task automatic push_a(input logic [4:0] d);
      int t;
      t = 0;
      a_in_valid = 1'b1;
      a_in_data  = d;
      @(negedge clk);
      while (!a_in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!a_in_ready) timeout("push_a");
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic pop_a(input string name, input logic [4:0] d, input logic l,
                        input logic [2:0] rows);
      int t;
      t = 0;
      a_out_ready = 1'b1;
      @(negedge clk);
      while (!a_out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!a_out_valid) timeout(name);
      else begin
         $display("%s: col=%b last=%0b rows=%0d", name, a_out_data, a_out_last, a_out_rows);
         chk({name, "_data"}, 32'(a_out_data), 32'(d));
         chk({name, "_last"}, 32'(a_out_last), 32'(l));
         chk({name, "_rows"}, 32'(a_out_rows), 32'(rows));
      end
      @(posedge clk); #1;
      a_out_ready = 1'b0;
   endtask

   task automatic sample_step();
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0][4:0] m0, m1, c0, c1;
      logic [4:0]      srow [20];
      logic [4:0]      sexp [20];

      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
`ifdef TRANSPOSE_BUF_FLUSH_EN
      a_flush = 1'b0; b_flush = 1'b0;
`endif

      // Vector table: hand-derived entries first, then random ones via the model.
      for (int i = 0; i < 5; i++) tbl[0].r[i] = 5'b00011;
      tbl[0].c[0] = 5'b11111; tbl[0].c[1] = 5'b11111;
      tbl[0].c[2] = 5'b00000; tbl[0].c[3] = 5'b00000; tbl[0].c[4] = 5'b00000;
      tbl[1].r[0] = 5'b00001; tbl[1].r[1] = 5'b00010; tbl[1].r[2] = 5'b00100;
      tbl[1].r[3] = 5'b01000; tbl[1].r[4] = 5'b10000;
      tbl[1].c[0] = 5'b00001; tbl[1].c[1] = 5'b00010; tbl[1].c[2] = 5'b00100;
      tbl[1].c[3] = 5'b01000; tbl[1].c[4] = 5'b10000;
      tbl[2].r[0] = 5'b11111;
      for (int i = 1; i < 5; i++) tbl[2].r[i] = 5'b00000;
      for (int j = 0; j < 5; j++) tbl[2].c[j] = 5'b00001;
      for (int i = 0; i < 5; i++) tbl[3].r[i] = 5'b10101;
      tbl[3].c[0] = 5'b11111; tbl[3].c[1] = 5'b00000; tbl[3].c[2] = 5'b11111;
      tbl[3].c[3] = 5'b00000; tbl[3].c[4] = 5'b11111;
      for (int k = 4; k < 8; k++) begin
         for (int i = 0; i < 5; i++) tbl[k].r[i] = 5'($urandom_range(0, 31));
         tbl[k].c = xpose5(tbl[k].r);
      end

      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_last", 32'(a_out_last), 32'd0);
      chk("rst_out_rows", 32'(a_out_rows), 32'd0);
      chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      sample_step();
      rst_n = 1'b1;
      sample_step();

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 4; i++) push_a(tbl[k].r[i]);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_before_last_row", k), 32'(a_out_valid), 32'd0);
         sample_step();
         push_a(tbl[k].r[4]);
         @(negedge clk);
         chk($sformatf("tbl%0d_valid_latency", k), 32'(a_out_valid), 32'd1);
         sample_step();
         for (int j = 0; j < 5; j++)
            pop_a($sformatf("tbl%0d_c%0d", k, j), tbl[k].c[j], 1'(j == 4), 3'd5);
      end

      // N=4, W=8: one-hot rows give one-hot columns followed by zero columns.
      for (int i = 0; i < 4; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = 8'(1 << i);
         @(negedge clk);
         chk($sformatf("b_in_ready_r%0d", i), 32'(b_in_ready), 32'd1);
         sample_step();
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         $display("b_c%0d: col=%b last=%0b rows=%0d", j, b_out_data, b_out_last, b_out_rows);
         chk($sformatf("b_c%0d_valid", j), 32'(b_out_valid), 32'd1);
         chk($sformatf("b_c%0d_data", j), 32'(b_out_data), (j < 4) ? 32'(1 << j) : 32'd0);
         chk($sformatf("b_c%0d_last", j), 32'(b_out_last), 32'(j == 7));
         chk($sformatf("b_c%0d_rows", j), 32'(b_out_rows), 32'd4);
         sample_step();
      end
      b_out_ready = 1'b0;

      // Backpressure: two full banks stall the writer until the first drains.
      for (int i = 0; i < 5; i++) begin
         m0[i] = 5'($urandom_range(0, 31));
         m1[i] = 5'($urandom_range(0, 31));
      end
      c0 = xpose5(m0);
      c1 = xpose5(m1);
      for (int i = 0; i < 5; i++) push_a(m0[i]);
      for (int i = 0; i < 4; i++) push_a(m1[i]);
      @(negedge clk);
      chk("bp_in_ready_after_9", 32'(a_in_ready), 32'd1);
      sample_step();
      push_a(m1[4]);
      @(negedge clk);
      chk("bp_in_ready_after_10", 32'(a_in_ready), 32'd0);
      sample_step();
      for (int j = 0; j < 4; j++) pop_a($sformatf("bp_m0_c%0d", j), c0[j], 1'b0, 3'd5);
      @(negedge clk);
      chk("bp_in_ready_before_last_col", 32'(a_in_ready), 32'd0);
      sample_step();
      pop_a("bp_m0_c4", c0[4], 1'b1, 3'd5);
      @(negedge clk);
      chk("bp_in_ready_after_drain", 32'(a_in_ready), 32'd1);
      chk("bp_second_valid", 32'(a_out_valid), 32'd1);
      sample_step();
      for (int j = 0; j < 5; j++) pop_a($sformatf("bp_m1_c%0d", j), c1[j], 1'(j == 4), 3'd5);
      @(negedge clk);
      chk("bp_empty_valid", 32'(a_out_valid), 32'd0);
      sample_step();

      // Streaming: 4 matrices back to back, columns expected in 20 consecutive cycles.
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < 5; i++) begin
            srow[m*5+i] = 5'($urandom_range(0, 31));
            m0[i] = srow[m*5+i];
         end
         c0 = xpose5(m0);
         for (int j = 0; j < 5; j++) sexp[m*5+j] = c0[j];
      end
      a_out_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               int t;
               t = 0;
               a_in_valid = 1'b1;
               a_in_data  = srow[k];
               @(negedge clk);
               while (!a_in_ready && t < 100) begin
                  @(negedge clk);
                  t++;
               end
               @(posedge clk); #1;
            end
            a_in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 25; c++) begin
               @(negedge clk);
               if (c < 5) begin
                  chk($sformatf("st_cyc%0d_valid", c), 32'(a_out_valid), 32'd0);
               end else begin
                  $display("st_c%0d: col=%b last=%0b", c - 5, a_out_data, a_out_last);
                  chk($sformatf("st_c%0d_valid", c - 5), 32'(a_out_valid), 32'd1);
                  chk($sformatf("st_c%0d_data", c - 5), 32'(a_out_data), 32'(sexp[c-5]));
                  chk($sformatf("st_c%0d_last", c - 5), 32'(a_out_last), 32'(((c - 5) % 5) == 4));
               end
               @(posedge clk); #1;
            end
         end
      join
      a_out_ready = 1'b0;
      sample_step();

      // Reset mid-drain, then a fresh matrix must start at column 0.
      for (int i = 0; i < 5; i++) m0[i] = 5'($urandom_range(0, 31));
      c0 = xpose5(m0);
      for (int i = 0; i < 5; i++) push_a(m0[i]);
      for (int j = 0; j < 2; j++) pop_a($sformatf("rs_pre_c%0d", j), c0[j], 1'b0, 3'd5);
      rst_n = 1'b0;
      #1;
      chk("rs_out_valid", 32'(a_out_valid), 32'd0);
      chk("rs_in_ready", 32'(a_in_ready), 32'd1);
      chk("rs_out_rows", 32'(a_out_rows), 32'd0);
      sample_step();
      rst_n = 1'b1;
      sample_step();
      for (int i = 0; i < 5; i++) m1[i] = 5'($urandom_range(0, 31));
      c1 = xpose5(m1);
      for (int i = 0; i < 5; i++) push_a(m1[i]);
      for (int j = 0; j < 5; j++) pop_a($sformatf("rs_post_c%0d", j), c1[j], 1'(j == 4), 3'd5);

`ifdef TRANSPOSE_BUF_FLUSH_EN
      // Partial matrix closed by flush: missing rows read as zero.
      for (int i = 0; i < 3; i++) push_a(5'b11111);
      a_flush = 1'b1;
      sample_step();
      a_flush = 1'b0;
      @(negedge clk);
      chk("fl_valid", 32'(a_out_valid), 32'd1);
      chk("fl_rows", 32'(a_out_rows), 32'd3);
      sample_step();
      for (int j = 0; j < 5; j++) pop_a($sformatf("fl_c%0d", j), 5'b00111, 1'(j == 4), 3'd3);

      a_flush = 1'b1;
      sample_step();
      a_flush = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("fl_empty_valid%0d", c), 32'(a_out_valid), 32'd0);
         sample_step();
      end

      // Flush together with an accepted row: the row counts toward rows.
      push_a(5'b10101);
      push_a(5'b10101);
      a_flush = 1'b1;
      push_a(5'b11111);
      a_flush = 1'b0;
      pop_a("flw_c0", 5'b00111, 1'b0, 3'd3);
      pop_a("flw_c1", 5'b00100, 1'b0, 3'd3);
      pop_a("flw_c2", 5'b00111, 1'b0, 3'd3);
      pop_a("flw_c3", 5'b00100, 1'b0, 3'd3);
      pop_a("flw_c4", 5'b00111, 1'b1, 3'd3);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
